// File: rtl/regfile_sweep_if.sv
// Bus bundle for regfile_sweep: write, read, pending, sweep and debug signals.
// Master drives the requests; slave is the register file.
interface regfile_sweep_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;
    logic              pend_readRegA;
    logic              pend_readRegB;
    logic              ctrl_setPending;
    logic [ADDR_W-1:0] ctrl_pendingReg;
    logic              ctrl_clear;
    logic              clear_busy;
    logic [ADDR_W-1:0] ctrl_debugReg;
    logic [DATA_W-1:0] data_debug;

    modport master (
        output ctrl_writeEnable,
        output ctrl_writeReg,
        output data_writeReg,
        output ctrl_readRegA,
        output ctrl_readRegB,
        input  data_readRegA,
        input  data_readRegB,
        input  pend_readRegA,
        input  pend_readRegB,
        output ctrl_setPending,
        output ctrl_pendingReg,
        output ctrl_clear,
        input  clear_busy,
        output ctrl_debugReg,
        input  data_debug
    );

    modport slave (
        input  ctrl_writeEnable,
        input  ctrl_writeReg,
        input  data_writeReg,
        input  ctrl_readRegA,
        input  ctrl_readRegB,
        output data_readRegA,
        output data_readRegB,
        output pend_readRegA,
        output pend_readRegB,
        input  ctrl_setPending,
        input  ctrl_pendingReg,
        input  ctrl_clear,
        output clear_busy,
        input  ctrl_debugReg,
        output data_debug
    );
endinterface

// File: rtl/regfile_sweep.sv
// Register file with pending scoreboard, soft-clear sweep and debug tap.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sweep #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic            clock,
    input  logic            ctrl_reset,
    regfile_sweep_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DATA_W-1:0] debug_q;

    logic              busy;
    logic              wr_ok;
    logic              set_ok;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              pend_a;
    logic              pend_b;

    assign busy   = (state == SWEEP);
    assign wr_ok  = bus.ctrl_writeEnable
                  && (bus.ctrl_writeReg != '0)
                  && !busy;
    assign set_ok = bus.ctrl_setPending
                  && (bus.ctrl_pendingReg != '0)
                  && !busy;

    assign bus.clear_busy    = busy;
    assign bus.data_debug    = debug_q;
    assign bus.data_readRegA = data_a;
    assign bus.data_readRegB = data_b;
    assign bus.pend_readRegA = pend_a;
    assign bus.pend_readRegB = pend_b;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend    <= '0;
            state   <= IDLE;
            idx     <= FIRST;
            debug_q <= '0;
        end else begin
            // Tap shows stored contents only, sampled before this edge's update.
            debug_q <= regs[bus.ctrl_debugReg];
            unique case (state)
                IDLE: begin
                    if (wr_ok) begin
                        regs[bus.ctrl_writeReg] <= bus.data_writeReg;
                        pend[bus.ctrl_writeReg] <= 1'b0;
                    end
                    // A same-cycle set overrides the write's clear.
                    if (set_ok) begin
                        pend[bus.ctrl_pendingReg] <= 1'b1;
                    end
                    if (bus.ctrl_clear) begin
                        state <= SWEEP;
                        idx   <= FIRST;
                    end
                end
                SWEEP: begin
                    regs[idx] <= '0;
                    pend[idx] <= 1'b0;
                    if (idx == LAST) begin
                        state <= IDLE;
                        idx   <= FIRST;
                    end else begin
                        idx <= idx + FIRST;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= FIRST;
                end
            endcase
        end
    end

    always_comb begin
        data_a = '0;
        pend_a = 1'b0;
        if (bus.ctrl_readRegA != '0) begin
            data_a = regs[bus.ctrl_readRegA];
            pend_a = pend[bus.ctrl_readRegA];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.ctrl_writeReg == bus.ctrl_readRegA)) begin
            data_a = bus.data_writeReg;
            pend_a = set_ok
                   && (bus.ctrl_pendingReg == bus.ctrl_readRegA);
        end
`endif
    end

    always_comb begin
        data_b = '0;
        pend_b = 1'b0;
        if (bus.ctrl_readRegB != '0) begin
            data_b = regs[bus.ctrl_readRegB];
            pend_b = pend[bus.ctrl_readRegB];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.ctrl_writeReg == bus.ctrl_readRegB)) begin
            data_b = bus.data_writeReg;
            pend_b = set_ok
                   && (bus.ctrl_pendingReg == bus.ctrl_readRegB);
        end
`endif
    end
endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: directed cases plus random traffic
// compared every cycle against an array-based model of the register file.
module tb_regfile_sweep;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic ctrl_reset = 1'b0;

    regfile_sweep_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sweep #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mregs [DEPTH];
    logic          mpend [DEPTH];
    logic [DW-1:0] mdebug;
    int            sweep_left = 0;
    bit            chk_en = 1'b0;

    task automatic check(input string name,
                         input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: registers as an array, sweep as a count of entries still to clear.
    always @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
            sweep_left = 0;
            mdebug = '0;
            chk_en = 1'b1;
        end else begin
            mdebug = mregs[bus.ctrl_debugReg];
            if (sweep_left > 0) begin
                int pos;
                pos = DEPTH - sweep_left;
                mregs[pos] = '0;
                mpend[pos] = 1'b0;
                sweep_left--;
            end else begin
                if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) begin
                    mregs[bus.ctrl_writeReg] = bus.data_writeReg;
                    mpend[bus.ctrl_writeReg] = 1'b0;
                end
                if (bus.ctrl_setPending && bus.ctrl_pendingReg != 0)
                    mpend[bus.ctrl_pendingReg] = 1'b1;
                if (bus.ctrl_clear)
                    sweep_left = DEPTH - 1;
            end
        end
    end

    function automatic logic fwd_hit(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        return sweep_left == 0 && bus.ctrl_writeEnable
            && bus.ctrl_writeReg == a && a != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (fwd_hit(a)) return bus.data_writeReg;
        return mregs[a];
    endfunction

    function automatic logic [DW-1:0] exp_pend(input logic [AW-1:0] a);
        if (fwd_hit(a))
            return DW'(bus.ctrl_setPending && bus.ctrl_pendingReg == a);
        return DW'(mpend[a]);
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("rdA", bus.data_readRegA, exp_data(bus.ctrl_readRegA));
            check("rdB", bus.data_readRegB, exp_data(bus.ctrl_readRegB));
            check("pendA", DW'(bus.pend_readRegA),
                  exp_pend(bus.ctrl_readRegA));
            check("pendB", DW'(bus.pend_readRegB),
                  exp_pend(bus.ctrl_readRegB));
            check("busy", DW'(bus.clear_busy), DW'(sweep_left > 0));
            check("debug", bus.data_debug, mdebug);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_setPending  = 1'b0;
        bus.ctrl_clear       = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [DW-1:0] old_val;
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = '0;
        bus.data_writeReg    = '0;
        bus.ctrl_readRegA    = '0;
        bus.ctrl_readRegB    = '0;
        bus.ctrl_setPending  = 1'b0;
        bus.ctrl_pendingReg  = '0;
        bus.ctrl_clear       = 1'b0;
        bus.ctrl_debugReg    = '0;
        ctrl_reset = 1'b0;
        step();
        step();
        ctrl_reset = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            bus.ctrl_readRegA = AW'(a);
            bus.ctrl_readRegB = AW'(DEPTH - 1 - a);
            bus.ctrl_debugReg = AW'(a);
            #1;
            check("rst_dataA", bus.data_readRegA, 32'h0);
            check("rst_pendA", DW'(bus.pend_readRegA), 32'h0);
            check("rst_busy", DW'(bus.clear_busy), 32'h0);
            check("rst_debug", bus.data_debug, 32'h0);
            step();
        end

        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg = 5'd5;
        bus.data_writeReg = 32'hDEADBEEF;
        bus.ctrl_readRegA = 5'd5;
        bus.ctrl_debugReg = 5'd5;
        step();
        bus.ctrl_writeReg = 5'd0;
        bus.data_writeReg = 32'h1234;
        bus.ctrl_readRegB = 5'd0;
        #1;
        check("r5_write", bus.data_readRegA, 32'hDEADBEEF);
        step();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        check("r0_write", bus.data_readRegB, 32'h0);
        check("debug_r5", bus.data_debug, 32'hDEADBEEF);

        bus.ctrl_setPending = 1'b1;
        bus.ctrl_pendingReg = 5'd7;
        bus.ctrl_readRegA = 5'd7;
        step();
        bus.ctrl_setPending = 1'b0;
        #1;
        check("r7_pend_set", DW'(bus.pend_readRegA), 32'h1);
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg = 5'd7;
        bus.data_writeReg = 32'h77;
        step();
        bus.ctrl_setPending = 1'b1;
        bus.data_writeReg = 32'h55;
        #1;
        check("r7_pend_wr", DW'(bus.pend_readRegA), 32'h0);
        check("r7_data77", bus.data_readRegA, 32'h77);
        step();
        idle_inputs();
        #1;
        check("r7_setwr_d", bus.data_readRegA, 32'h55);
        check("r7_setwr_p", DW'(bus.pend_readRegA), 32'h1);

        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg = 5'd3;
        bus.data_writeReg = 32'h1111;
        step();
        bus.data_writeReg = 32'hA5A5A5A5;
        bus.ctrl_readRegA = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("raw_same", bus.data_readRegA, 32'hA5A5A5A5);
`else
        check("raw_same", bus.data_readRegA, 32'h1111);
`endif
        step();
        bus.ctrl_writeEnable = 1'b0;
        #1;
        check("raw_next", bus.data_readRegA, 32'hA5A5A5A5);

        for (int a = 1; a < DEPTH; a++) begin
            bus.ctrl_writeEnable = 1'b1;
            bus.ctrl_writeReg = AW'(a);
            bus.data_writeReg = 32'h100 + a;
            step();
        end
        idle_inputs();

        bus.ctrl_clear = 1'b1;
        bus.ctrl_readRegA = 5'd1;
        bus.ctrl_readRegB = 5'd9;
        step();
        bus.ctrl_clear = 1'b0;
        cnt = 0;
        while (bus.clear_busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
                #1;
                check("sweep_r1", bus.data_readRegA, 32'h0);
            end
            if (cnt == 20) begin
                bus.ctrl_writeEnable = 1'b1;
                bus.ctrl_writeReg = 5'd9;
                bus.data_writeReg = 32'h999;
            end
            if (cnt == 21) bus.ctrl_writeEnable = 1'b0;
            step();
        end
        bus.ctrl_writeEnable = 1'b0;
        check("sweep_len", DW'(cnt), 32'd31);
        #1;
        check("sweep_r9", bus.data_readRegB, 32'h0);

        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg = 5'd2;
        bus.data_writeReg = 32'hABC;
        step();
        bus.ctrl_writeReg = 5'd30;
        bus.data_writeReg = 32'hDEF;
        step();
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_readRegA = 5'd2;
        bus.ctrl_readRegB = 5'd30;
        bus.ctrl_clear = 1'b1;
        step();
        bus.ctrl_clear = 1'b0;
        cnt = 0;
        while (bus.clear_busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 10) begin
                ctrl_reset = 1'b0;
                step();
                ctrl_reset = 1'b1;
                break;
            end
            step();
        end
        #1;
        check("abort_cnt", DW'(cnt), 32'd10);
        check("abort_busy", DW'(bus.clear_busy), 32'h0);
        check("abort_r2", bus.data_readRegA, 32'h0);
        check("abort_r30", bus.data_readRegB, 32'h0);

        bus.ctrl_clear = 1'b1;
        step();
        cnt = 0;
        while (bus.clear_busy === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        check("held_len", DW'(cnt), 32'd31);
        step();
        bus.ctrl_clear = 1'b0;
        check("held_restart", DW'(bus.clear_busy), 32'h1);
        cnt = 0;
        while (bus.clear_busy === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        check("held_len2", DW'(cnt), 32'd31);

        for (int n = 0; n < 1500; n++) begin
            ctrl_reset = ($urandom_range(0, 199) != 0);
            bus.ctrl_writeEnable = $urandom_range(0, 1) == 1;
            bus.ctrl_setPending = $urandom_range(0, 9) < 3;
            bus.ctrl_clear = $urandom_range(0, 63) == 0;
            if ($urandom_range(0, 1) == 1) begin
                bus.ctrl_writeReg = AW'($urandom_range(0, 3));
                bus.ctrl_pendingReg = AW'($urandom_range(0, 3));
                bus.ctrl_readRegA = AW'($urandom_range(0, 3));
                bus.ctrl_readRegB = AW'($urandom_range(0, 3));
            end else begin
                bus.ctrl_writeReg = AW'($urandom);
                bus.ctrl_pendingReg = AW'($urandom);
                bus.ctrl_readRegA = AW'($urandom);
                bus.ctrl_readRegB = AW'($urandom);
            end
            bus.data_writeReg = $urandom;
            bus.ctrl_debugReg = AW'($urandom);
            step();
        end

        ctrl_reset = 1'b1;
        idle_inputs();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
